// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg: shared state encoding, FIFO entry layout and fetch defaults.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int          INSTR_BYTES  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'd0;
  localparam logic [31:0] DEF_PC_LIMIT = 32'd20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo: 2-entry {pc, word} buffer with registered head and flush.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] din,
  output logic [1:0]  count,
  output logic [63:0] head
);

  logic [63:0] slot1;

  // The head only moves when a newer entry replaces it, so it holds its last
  // value once the buffer drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= 64'd0;
      slot1 <= 64'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head  <= slot1;
            slot1 <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl: credit-throttled instruction fetch sequencer with redirect.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] PC_LIMIT  = DEF_PC_LIMIT,
  parameter int          MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [31:0] PC_STEP   = 32'(INSTR_BYTES);

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] inflight_pc, inflight_pc_nx;
  logic        inflight, inflight_nx;
  logic        err_nx;

  logic [1:0]  count;
  logic [63:0] head;
  logic        pop, push, redir, issue, redir_bad;
  logic [2:0]  credits;
  logic [31:0] redir_aligned;
  entry_t      push_entry;

  assign pop           = instr_valid && instr_ready;
  assign redir         = (state == ST_FETCH) && redirect_valid;
  assign push          = inflight && !redir;
  // Slots committed after this edge: buffered words less the one leaving,
  // plus the word already on its way back from memory.
  assign credits       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue         = (state == ST_FETCH) && !redir && (fetch_pc < PC_LIMIT)
                         && (credits < 3'd2);
  assign redir_aligned = {redirect_pc[31:2], 2'b00};
  assign redir_bad     = (redirect_pc[1:0] != 2'b00) || (redir_aligned >= MEM_LIMIT);
  assign push_entry    = '{pc: inflight_pc, word: imem_data};

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

  always_comb begin
    state_nx       = state;
    fetch_pc_nx    = fetch_pc;
    inflight_nx    = 1'b0;
    inflight_pc_nx = inflight_pc;
    err_nx         = err;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx    = ST_FETCH;
          fetch_pc_nx = RESET_PC;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nx    = ST_FETCH;
          fetch_pc_nx = RESET_PC;
          err_nx      = 1'b0;
        end
      end
      ST_FETCH: begin
        if (redir) begin
          fetch_pc_nx = redir_aligned;
          if (redir_bad) err_nx = 1'b1;
        end else begin
          if (issue) begin
            inflight_nx    = 1'b1;
            inflight_pc_nx = fetch_pc;
            fetch_pc_nx    = fetch_pc + PC_STEP;
          end
          if ((fetch_pc >= PC_LIMIT) && !inflight && (count == 2'd0))
            state_nx = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      fetch_pc    <= fetch_pc_nx;
      inflight    <= inflight_nx;
      inflight_pc <= inflight_pc_nx;
      err         <= err_nx;
    end
  end

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = head[31:0];
  assign instr_pc    = head[63:32];
  assign busy        = (state == ST_FETCH);
  assign done        = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl: directed vector table plus hand-written corner sequences.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, redirect_valid, instr_ready;
  logic [31:0] redirect_pc, imem_addr, instr, instr_pc;
  logic [31:0] imem_data = 32'd0;
  logic        instr_valid, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] img [5] = '{32'h0001F820, 32'h0021F020, 32'h0022E820,
                           32'h0043E020, 32'h0065D820};
  logic [7:0]  mem [128];

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic        exp_busy;
    logic        exp_done;
    logic        chk_data;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] log_pc [$];
  logic [31:0] log_word [$];
  logic [31:0] exp_q [$];

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Byte-addressed big-endian memory with one edge of read latency.
  always @(posedge clk) begin
    logic [6:0] a;
    a = imem_addr[6:0];
    imem_data <= {mem[a], mem[a + 7'd1], mem[a + 7'd2], mem[a + 7'd3]};
  end

  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      log_pc.push_back(instr_pc);
      log_word.push_back(instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 50) begin
      tick();
      n++;
    end
    chk(name, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic redir_pulse(input logic [31:0] rpc);
    redirect_valid = 1'b1;
    redirect_pc    = rpc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_log(input string name);
    chk($sformatf("%s_len", name), 32'(log_pc.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_pc.size(); i++) begin
      chk($sformatf("%s_pc%0d", name, i), log_pc[i], exp_q[i]);
      chk($sformatf("%s_word%0d", name, i), log_word[i], img[exp_q[i] >> 2]);
    end
    log_pc.delete();
    log_word.delete();
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 9; i++) begin
      start       = tbl[i].start;
      instr_ready = tbl[i].ready;
      tick();
      chk($sformatf("%s_r%0d_valid", tag, i), {31'd0, instr_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("%s_r%0d_busy", tag, i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
      chk($sformatf("%s_r%0d_done", tag, i), {31'd0, done}, {31'd0, tbl[i].exp_done});
      chk($sformatf("%s_r%0d_addr", tag, i), imem_addr, tbl[i].exp_addr);
      if (tbl[i].chk_data) begin
        chk($sformatf("%s_r%0d_instr", tag, i), instr, tbl[i].exp_instr);
        chk($sformatf("%s_r%0d_pc", tag, i), instr_pc, tbl[i].exp_pc);
      end
    end
    start = 1'b0;
    log_pc.delete();
    log_word.delete();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    for (int w = 0; w < 5; w++) begin
      mem[4*w]     = img[w][31:24];
      mem[4*w + 1] = img[w][23:16];
      mem[4*w + 2] = img[w][15:8];
      mem[4*w + 3] = img[w][7:0];
    end

    // start ready valid busy done chk_data instr pc addr (after the edge)
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'd0,  32'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'd0,  32'd4};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0001F820, 32'd0,  32'd8};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0021F020, 32'd4,  32'd12};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0022E820, 32'd8,  32'd16};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0043E020, 32'd12, 32'd20};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0065D820, 32'd16, 32'd20};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0065D820, 32'd16, 32'd20};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0065D820, 32'd16, 32'd20};

    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    rst_n = 1'b1;
    tick();

    run_table("first");
    run_table("restart");

    // Backpressure: stall after the first word is visible.
    instr_ready = 1'b1;
    pulse_start();
    wait_valid("bp_first_valid");
    instr_ready = 1'b0;
    repeat (2) tick();
    chk("bp_addr_stalled_a", imem_addr, 32'd8);
    repeat (4) tick();
    chk("bp_addr_stalled_b", imem_addr, 32'd8);
    chk("bp_head_pc", instr_pc, 32'd0);
    chk("bp_head_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    wait_done("bp_done");
    exp_q = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
    check_log("bp_log");

    // Redirect to 12 while pc 4 is in flight.
    pulse_start();
    wait_valid("rd_first_valid");
    redir_pulse(32'd12);
    chk("rd_flushed", {31'd0, instr_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'd12);
    chk("rd_err", {31'd0, err}, 32'd0);
    wait_done("rd_done");
    exp_q = '{32'd0, 32'd12, 32'd16};
    check_log("rd_log");

    // Misaligned redirect: aligned to 8, err sticky until restart.
    pulse_start();
    wait_valid("mis_first_valid");
    redir_pulse(32'h9);
    chk("mis_err_set", {31'd0, err}, 32'd1);
    chk("mis_addr", imem_addr, 32'd8);
    wait_done("mis_done");
    chk("mis_err_in_done", {31'd0, err}, 32'd1);
    exp_q = '{32'd0, 32'd8, 32'd12, 32'd16};
    check_log("mis_log");
    pulse_start();
    chk("mis_err_cleared", {31'd0, err}, 32'd0);
    wait_done("mis_rerun_done");
    log_pc.delete();
    log_word.delete();

    // Out-of-range redirect goes straight to DONE with err.
    pulse_start();
    wait_valid("oor_first_valid");
    redir_pulse(32'h100);
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("oor_done", {31'd0, done}, 32'd1);
    exp_q = '{32'd0};
    check_log("oor_log");

    // Async reset with two words buffered and err set.
    pulse_start();
    wait_valid("ar_first_valid");
    instr_ready = 1'b0;
    redir_pulse(32'h9);
    repeat (4) tick();
    chk("ar_pre_err", {31'd0, err}, 32'd1);
    chk("ar_pre_valid", {31'd0, instr_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_err", {31'd0, err}, 32'd0);
    chk("ar_addr", imem_addr, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    log_pc.delete();
    log_word.delete();
    run_table("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
